alu_arbiter: RTL
================

# alu_arbiter

Two-port arbiter and sequencer for the shared single-cycle `alu`. Two requesters issue ALU operations: the execute stage on port 0 and the address/branch helper on port 1. The block accepts one request at a time through a valid/ready handshake and registers its operands. It drives the `alu` for exactly one cycle, then holds the registered result on the owning requester's response channel until that requester accepts it.

## Interface

Parameters:
- `DATA_W`, 32: operand/result width; must equal the `alu` width.

Ports (`N` ∈ {0,1}, one set per requester):
- Clock and reset:
  - `clk` input 1: single clock; all state updates on the rising edge.
  - `rst_n` input 1: reset, asynchronous, active-low.
- Request channel:
  - `reqN_valid` input 1: request present.
  - `reqN_ready` output 1: request accepted this cycle when high together with `reqN_valid`.
  - `reqN_funct3` input 3: ALU operation code.
  - `reqN_funct7` input 7: ALU alternate-action code.
  - `reqN_src_sel` input 1: second-operand select, passed through to the `alu`.
  - `reqN_op_a`, `reqN_op_b`, `reqN_imm` input DATA_W: first operand, register second operand, immediate second operand.
- Response channel:
  - `respN_valid` output 1: result available.
  - `respN_data` output DATA_W: result.
  - `respN_ready` input 1: requester takes the result.
- ALU side:
  - `alu_en` output 1: ALU enable.
  - `alu_funct3` output 3, `alu_funct7` output 7, `alu_src_sel` output 1: operation fields to the `alu`.
  - `alu_reg_data_1`, `alu_reg_data_2`, `alu_immediate` output DATA_W: operands to the `alu`.
  - `alu_res` input DATA_W: combinational ALU result.

## Operation

- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - Grant goes to a valid requester. If both are valid, the grant goes to the one not granted last (pointer `last`, reset value 1, so port 0 wins first).
  - `reqN_ready` is high only for the granted port. It is combinational from the `valid` inputs and the pointer, and is low outside IDLE.
  - On acceptance: capture `funct3`, `funct7`, `src_sel`, `op_a`, `op_b` and `imm` into operand registers, record the owner, set `last` to the owner, and go to ISSUE.
- **ISSUE**
  - `alu_en`=1 and the `alu_*` outputs carry the operand registers.
  - `alu_res` is captured into the result register and the FSM goes to RESP unconditionally.
- **RESP**
  - `resp<owner>_valid`=1 and `resp<owner>_data` = result register. The other port's `resp_valid` is 0.
  - On `resp<owner>_ready`=1, go to IDLE.
- `respN_data` holds the result register for both ports and is qualified only by `respN_valid`.
- Outside ISSUE: `alu_en`=0, and the `alu_*` operand and operation outputs keep their register values. The `alu` then outputs 0, which is ignored.
- Requesters may drop `valid` before acceptance without penalty. Operands need to be stable only in the acceptance cycle.
- Unsupported `funct3` values are passed through unchanged. The result is whatever the `alu` returns (0).
- No arithmetic is performed in this block. All widths pass through unchanged.

## Timing

- Reset values: state IDLE, `last`=1, all operand and result registers 0, `alu_en`=0, `respN_valid`=0, `respN_data`=0. `reqN_ready` follows IDLE grant logic immediately after reset.
- Acceptance at rising edge k: `alu_en` is high during cycle k→k+1. `respN_valid` is high from edge k+1.
- Minimum latency from acceptance edge to `resp_valid` is 1 cycle. Minimum spacing between acceptances is 3 edges (IDLE→ISSUE→RESP→IDLE).
- While `resp_ready` is low in RESP: `resp_valid` and `resp_data` stay stable, and no new request is accepted on either port.
- Simultaneous `valid` on both ports: exactly one `ready` is asserted, never both.
- Reset asserted in any state: registers clear immediately (asynchronous), an in-flight result is discarded, and no response is produced for it.

## Configuration

- `ALU_ARB_FAIR_EN`
  - Defined: round-robin grant using `last`, as described above.
  - Undefined: fixed priority, port 0 always wins on simultaneous requests. `last` is not implemented, and port 1 is granted only when `req0_valid`=0 in IDLE.

## Test plan

- After reset, `req0` ADD (`funct3`=000, `src_sel`=1, `op_a`=5, `op_b`=7) → `req0_ready` on the first edge, `alu_en` for one cycle, `resp0_valid` with `resp0_data`=12 one edge later; `resp1_valid` stays 0.
- Both valid in the same cycle: `req0` XOR 0xF0^0xFF, `req1` SLT signed −1<1 → port 0 served first (`resp0_data`=0x0F), then port 1 (`resp1_data`=1).
- Both ports continuously valid, `resp_ready`=1, 4 operations → grant order 0,1,0,1 with FAIR_EN defined; 0,0,0,0 without it.
- `resp0_ready` held low for 5 cycles in RESP with `req1_valid`=1 → `resp0_valid`/`resp0_data` stable, `req1_ready`=0 throughout; `req1` accepted on the first IDLE cycle after the handshake.
- Immediate-path subtract (`src_sel`=0, `funct7`=0100000, `op_a`=10, `imm`=3, `op_b`=99) → `resp_data`=7.
- `rst_n` pulsed low during ISSUE → `alu_en`, `resp*_valid`=0 immediately, no response issued; the following ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port valid/ready arbiter and sequencer for the shared
// single-cycle alu. Accepts one request, drives the alu for one cycle, then
// holds the registered result on the owner's response channel until taken.
// Optional feature macro: ALU_ARB_FAIR_EN (round-robin grant via `last`);
// when undefined, port 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 (execute stage)
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_funct3,
  input  logic [6:0]        req0_funct7,
  input  logic              req0_src_sel,
  input  logic [DATA_W-1:0] req0_op_a,
  input  logic [DATA_W-1:0] req0_op_b,
  input  logic [DATA_W-1:0] req0_imm,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  input  logic              resp0_ready,
  // requester 1 (address/branch helper)
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_funct3,
  input  logic [6:0]        req1_funct7,
  input  logic              req1_src_sel,
  input  logic [DATA_W-1:0] req1_op_a,
  input  logic [DATA_W-1:0] req1_op_b,
  input  logic [DATA_W-1:0] req1_imm,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,
  input  logic              resp1_ready,
  // alu side
  output logic              alu_en,
  output logic [2:0]        alu_funct3,
  output logic [6:0]        alu_funct7,
  output logic              alu_src_sel,
  output logic [DATA_W-1:0] alu_reg_data_1,
  output logic [DATA_W-1:0] alu_reg_data_2,
  output logic [DATA_W-1:0] alu_immediate,
  input  logic [DATA_W-1:0] alu_res
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner;
`ifdef ALU_ARB_FAIR_EN
  logic                r_last;
`endif
  logic [2:0]          r_funct3;
  logic [6:0]          r_funct7;
  logic                r_src_sel;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_result;
  logic                r_alu_en;
  logic                r_resp0_valid;
  logic                r_resp1_valid;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_accept;
  logic                w_resp_take;

  // Grant decision: only in IDLE, exactly one port on simultaneous requests.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FAIR_EN
        // port not granted last wins; r_last resets to 1 so port 0 goes first
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
`else
        w_gnt0 = 1'b1;
        w_gnt1 = 1'b0;
`endif
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_accept    = w_gnt0 | w_gnt1;
  assign w_resp_take = r_owner ? resp1_ready : resp0_ready;

  assign req0_ready     = w_gnt0;
  assign req1_ready     = w_gnt1;
  assign resp0_valid    = r_resp0_valid;
  assign resp1_valid    = r_resp1_valid;
  assign resp0_data     = r_result;
  assign resp1_data     = r_result;
  assign alu_en         = r_alu_en;
  assign alu_funct3     = r_funct3;
  assign alu_funct7     = r_funct7;
  assign alu_src_sel    = r_src_sel;
  assign alu_reg_data_1 = r_op_a;
  assign alu_reg_data_2 = r_op_b;
  assign alu_immediate  = r_imm;

  // Sequencer FSM: capture request, issue to alu for one cycle, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
`ifdef ALU_ARB_FAIR_EN
      r_last        <= 1'b1;
`endif
      r_funct3      <= 3'd0;
      r_funct7      <= 7'd0;
      r_src_sel     <= 1'b0;
      r_op_a        <= {DATA_W{1'b0}};
      r_op_b        <= {DATA_W{1'b0}};
      r_imm         <= {DATA_W{1'b0}};
      r_result      <= {DATA_W{1'b0}};
      r_alu_en      <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3  <= w_gnt1 ? req1_funct3  : req0_funct3;
            r_funct7  <= w_gnt1 ? req1_funct7  : req0_funct7;
            r_src_sel <= w_gnt1 ? req1_src_sel : req0_src_sel;
            r_op_a    <= w_gnt1 ? req1_op_a    : req0_op_a;
            r_op_b    <= w_gnt1 ? req1_op_b    : req0_op_b;
            r_imm     <= w_gnt1 ? req1_imm     : req0_imm;
            r_owner   <= w_gnt1;
`ifdef ALU_ARB_FAIR_EN
            r_last    <= w_gnt1;
`endif
            r_alu_en  <= 1'b1;
            r_state   <= S_ISSUE;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_result      <= alu_res;
          r_alu_en      <= 1'b0;
          r_resp0_valid <= ~r_owner;
          r_resp1_valid <= r_owner;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_take) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_state       <= S_RESP;
          end
        end
        default: begin
          r_alu_en      <= 1'b0;
          r_resp0_valid <= 1'b0;
          r_resp1_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
